// File: rtl/branch_redirect_ctrl.sv
// Branch redirect controller: after a branch/jump resolves in EX, issues a held
// PC redirect to fetch (valid/ready), flushes wrong-path IF/ID and ID/EX
// contents, drains in-flight IROM responses, and counts branches.
//
// Ports:
//   clk, rst                 clock, async active-high reset
//   ex_valid, ex_is_branch   EX holds a valid branch/jump instruction
//   ex_taken, ex_target      EX evaluator decision and target
//   redir_valid, redir_pc    registered redirect request to fetch
//   redir_ready              fetch accepts the redirect
//   flush_if_id, flush_id_ex combinational pipeline kills
//   target_misaligned        combinational pulse on a taken target with [1:0] != 0
//   busy                     controller not idle; ID must not issue
//   br_cnt, taken_cnt        saturating statistics counters
module branch_redirect_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ex_valid,
  input  logic             ex_is_branch,
  input  logic             ex_taken,
  input  logic [31:0]      ex_target,
  output logic             redir_valid,
  output logic [31:0]      redir_pc,
  input  logic             redir_ready,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic             target_misaligned,
  output logic             busy,
  output logic [CNT_W-1:0] br_cnt,
  output logic [CNT_W-1:0] taken_cnt
);

  localparam int unsigned DRAIN_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic               redir_valid_q, redir_valid_d;
  logic [31:0]        redir_pc_q, redir_pc_d;
  logic [CNT_W-1:0]   br_cnt_q, br_cnt_d;
  logic [CNT_W-1:0]   taken_cnt_q, taken_cnt_d;
  logic [DRAIN_W-1:0] drain_q, drain_d;
  logic               resolve;

  assign resolve = ex_valid & ex_is_branch;

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      redir_valid_q <= 1'b0;
      redir_pc_q    <= 32'd0;
      br_cnt_q      <= '0;
      taken_cnt_q   <= '0;
      drain_q       <= '0;
    end else begin
      state_q       <= state_d;
      redir_valid_q <= redir_valid_d;
      redir_pc_q    <= redir_pc_d;
      br_cnt_q      <= br_cnt_d;
      taken_cnt_q   <= taken_cnt_d;
      drain_q       <= drain_d;
    end
  end

  // Next-state, counters and combinational flush outputs
  always_comb begin
    state_d           = state_q;
    redir_valid_d     = redir_valid_q;
    redir_pc_d        = redir_pc_q;
    br_cnt_d          = br_cnt_q;
    taken_cnt_d       = taken_cnt_q;
    drain_d           = drain_q;
    flush_if_id       = 1'b0;
    flush_id_ex       = 1'b0;
    target_misaligned = 1'b0;

    case (state_q)
      IDLE: begin
        if (resolve) begin
          if (br_cnt_q != {CNT_W{1'b1}}) br_cnt_d = br_cnt_q + CNT_W'(1);
          if (ex_taken) begin
            if (taken_cnt_q != {CNT_W{1'b1}}) taken_cnt_d = taken_cnt_q + CNT_W'(1);
            flush_if_id       = 1'b1;
            flush_id_ex       = 1'b1;
            target_misaligned = |ex_target[1:0];
            redir_pc_d        = {ex_target[31:2], 2'b00};
            redir_valid_d     = 1'b1;
            state_d           = REQ;
          end
        end
      end
      REQ: begin
        flush_if_id = 1'b1;
        flush_id_ex = 1'b1;
        if (redir_ready) begin
          redir_valid_d = 1'b0;
          if (FLUSH_CYCLES == 0) begin
            state_d = IDLE;
          end else begin
            drain_d = DRAIN_W'(FLUSH_CYCLES);
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        // Late IROM responses still land in IF/ID; ID/EX is already clean.
        flush_if_id = 1'b1;
        if (drain_q <= DRAIN_W'(1)) begin
          drain_d = '0;
          state_d = IDLE;
        end else begin
          drain_d = drain_q - DRAIN_W'(1);
        end
      end
      default: begin
        state_d       = IDLE;
        redir_valid_d = 1'b0;
      end
    endcase
  end

  assign redir_valid = redir_valid_q;
  assign redir_pc    = redir_pc_q;
  assign br_cnt      = br_cnt_q;
  assign taken_cnt   = taken_cnt_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Directed bench for branch_redirect_ctrl: three instances share stimulus
// (a: FLUSH_CYCLES=1, b: FLUSH_CYCLES=2, c: FLUSH_CYCLES=1 with 2-bit counters).
module tb_branch_redirect_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ex_is_branch, ex_taken, redir_ready;
  logic [31:0] ex_target;

  logic        rv_a, fi_a, fe_a, mis_a, busy_a;
  logic [31:0] pc_a, br_a, tk_a;
  logic        rv_b, fi_b, fe_b, mis_b, busy_b;
  logic [31:0] pc_b, br_b, tk_b;
  logic        rv_c, fi_c, fe_c, mis_c, busy_c;
  logic [31:0] pc_c;
  logic [1:0]  br_c, tk_c;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  branch_redirect_ctrl #(.FLUSH_CYCLES(1), .CNT_W(32)) u_a (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_is_branch(ex_is_branch),
    .ex_taken(ex_taken), .ex_target(ex_target), .redir_valid(rv_a), .redir_pc(pc_a),
    .redir_ready(redir_ready), .flush_if_id(fi_a), .flush_id_ex(fe_a),
    .target_misaligned(mis_a), .busy(busy_a), .br_cnt(br_a), .taken_cnt(tk_a));

  branch_redirect_ctrl #(.FLUSH_CYCLES(2), .CNT_W(32)) u_b (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_is_branch(ex_is_branch),
    .ex_taken(ex_taken), .ex_target(ex_target), .redir_valid(rv_b), .redir_pc(pc_b),
    .redir_ready(redir_ready), .flush_if_id(fi_b), .flush_id_ex(fe_b),
    .target_misaligned(mis_b), .busy(busy_b), .br_cnt(br_b), .taken_cnt(tk_b));

  branch_redirect_ctrl #(.FLUSH_CYCLES(1), .CNT_W(2)) u_c (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_is_branch(ex_is_branch),
    .ex_taken(ex_taken), .ex_target(ex_target), .redir_valid(rv_c), .redir_pc(pc_c),
    .redir_ready(redir_ready), .flush_if_id(fi_c), .flush_id_ex(fe_c),
    .target_misaligned(mis_c), .busy(busy_c), .br_cnt(br_c), .taken_cnt(tk_c));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are then driven at +1 and outputs checked at +2.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic br, input logic tk, input logic [31:0] tgt);
    ex_valid     = v;
    ex_is_branch = br;
    ex_taken     = tk;
    ex_target    = tgt;
  endtask

  initial begin
    rst = 1'b1;
    redir_ready = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'd0);

    // 1. Reset state
    #3;
    chk("rst_rv", rv_a, 0);
    chk("rst_pc", pc_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_flush", {fi_a, fe_a, mis_a}, 0);
    cyc();
    rst = 1'b0;
    #1;
    chk("rst_br", br_a, 0);
    chk("rst_tk", tk_a, 0);

    // 2. Not-taken beq
    cyc();
    drive(1'b1, 1'b1, 1'b0, 32'h1C00_0080);
    #1;
    chk("nt_flush_if", fi_a, 0);
    chk("nt_flush_ex", fe_a, 0);
    cyc();
    drive(1'b0, 1'b0, 1'b0, 32'd0);
    #1;
    chk("nt_br", br_a, 1);
    chk("nt_tk", tk_a, 0);
    chk("nt_rv", rv_a, 0);
    chk("nt_busy", busy_a, 0);

    // 3. Taken bl, immediate ready, FLUSH_CYCLES=1 (instance a)
    cyc();
    drive(1'b1, 1'b1, 1'b1, 32'h1C00_0040);
    #1;
    chk("t3_T_fi", fi_a, 1);
    chk("t3_T_fe", fe_a, 1);
    chk("t3_T_mis", mis_a, 0);
    chk("t3_T_rv", rv_a, 0);
    cyc();
    drive(1'b0, 1'b0, 1'b0, 32'd0);
    redir_ready = 1'b1;
    #1;
    chk("t3_T1_rv", rv_a, 1);
    chk("t3_T1_pc", pc_a, 32'h1C00_0040);
    chk("t3_T1_br", br_a, 2);
    chk("t3_T1_tk", tk_a, 1);
    chk("t3_T1_fe", fe_a, 1);
    cyc();
    redir_ready = 1'b0;
    #1;
    chk("t3_T2_rv", rv_a, 0);
    chk("t3_T2_fi", fi_a, 1);
    chk("t3_T2_fe", fe_a, 0);
    chk("t3_T2_busy", busy_a, 1);
    cyc();
    #1;
    chk("t3_T3_busy", busy_a, 0);
    chk("t3_T3_fi", fi_a, 0);
    chk("t3_T3_b_busy", busy_b, 1);
    cyc();
    #1;
    chk("t3_T4_b_busy", busy_b, 0);

    // 4. Stalled fetch, FLUSH_CYCLES=2 (instance b); counters cleared by a mid-cycle reset
    rst = 1'b1;
    #2;
    rst = 1'b0;
    chk("t4_rst_br", br_b, 0);
    cyc();
    drive(1'b1, 1'b1, 1'b1, 32'h1C00_0100);
    #1;
    chk("t4_T_fe", fe_b, 1);
    cyc();
    drive(1'b1, 1'b1, 1'b1, 32'h1C00_0200);
    #1;
    chk("t4_T1_rv", rv_b, 1);
    chk("t4_T1_pc", pc_b, 32'h1C00_0100);
    chk("t4_T1_fi", fi_b, 1);
    chk("t4_T1_fe", fe_b, 1);
    cyc();
    #1;
    chk("t4_T2_pc", pc_b, 32'h1C00_0100);
    cyc();
    drive(1'b0, 1'b0, 1'b0, 32'd0);
    #1;
    chk("t4_T3_rv", rv_b, 1);
    chk("t4_T3_pc", pc_b, 32'h1C00_0100);
    cyc();
    redir_ready = 1'b1;
    #1;
    chk("t4_T4_rv", rv_b, 1);
    chk("t4_T4_br", br_b, 1);
    chk("t4_T4_tk", tk_b, 1);
    cyc();
    redir_ready = 1'b0;
    #1;
    chk("t4_D1_rv", rv_b, 0);
    chk("t4_D1_fi", fi_b, 1);
    chk("t4_D1_fe", fe_b, 0);
    chk("t4_D1_busy", busy_b, 1);
    cyc();
    #1;
    chk("t4_D2_busy", busy_b, 1);
    chk("t4_D2_fi", fi_b, 1);
    cyc();
    #1;
    chk("t4_end_busy", busy_b, 0);
    chk("t4_end_fi", fi_b, 0);
    chk("t4_end_br", br_b, 1);

    // 5. Misaligned jirl (instance a)
    cyc();
    drive(1'b1, 1'b1, 1'b1, 32'h1C00_0046);
    #1;
    chk("t5_T_mis", mis_a, 1);
    cyc();
    drive(1'b0, 1'b0, 1'b0, 32'd0);
    redir_ready = 1'b1;
    #1;
    chk("t5_T1_mis", mis_a, 0);
    chk("t5_T1_pc", pc_a, 32'h1C00_0044);
    cyc();
    redir_ready = 1'b0;
    cyc();
    cyc();
    #1;
    chk("t5_idle_b", busy_b, 0);

    // 6a. Reset during REQ
    drive(1'b1, 1'b1, 1'b1, 32'h1C00_0300);
    #1;
    cyc();
    drive(1'b0, 1'b0, 1'b0, 32'd0);
    #1;
    chk("t6_req_rv", rv_a, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_async_rv", rv_a, 0);
    chk("t6_async_busy", busy_a, 0);
    chk("t6_async_fi", fi_a, 0);
    rst = 1'b0;
    cyc();
    #1;
    chk("t6_post_rv", rv_a, 0);
    chk("t6_post_busy", busy_a, 0);
    chk("t6_post_br", br_a, 0);

    // 6b. Five taken branches, each in the first IDLE cycle after the previous drain
    redir_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b1, 1'b1, 32'h1C00_0400 + 32'(i * 16));
      #1;
      chk($sformatf("t6_accept%0d", i), fe_c, 1);
      cyc();
      drive(1'b0, 1'b0, 1'b0, 32'd0);
      cyc();
      cyc();
    end
    redir_ready = 1'b0;
    cyc();
    cyc();
    #1;
    chk("t6_sat_br", br_c, 3);
    chk("t6_sat_tk", tk_c, 3);
    chk("t6_wide_br", br_a, 5);
    chk("t6_wide_tk", tk_a, 5);
    chk("t6_idle_c", busy_c, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
